// File: rtl/btn_event_pkg.sv
// rtl/btn_event_pkg.sv - shared types and constants for the button event controller
package btn_event_pkg;

  typedef enum logic [1:0] {
    EV_PRESS   = 2'd0,
    EV_LONG    = 2'd1,
    EV_REPEAT  = 2'd2,
    EV_RELEASE = 2'd3
  } event_kind_t;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    HELD        = 2'd1,
    REPEAT_HOLD = 2'd2
  } btn_state_t;

  // clock cycles per ms = frequency / MS_DIVISOR
  localparam int unsigned MS_DIVISOR = 1000;

endpackage

// File: rtl/button_hold_fsm.sv
// rtl/button_hold_fsm.sv - per-button press/long/repeat/release event generator
module button_hold_fsm
  import btn_event_pkg::*;
#(
  parameter int unsigned LONG_MS   = 1000,
  parameter int unsigned REPEAT_MS = 200,
  parameter int unsigned CNT_W     = 10
) (
  input  logic clock,
  input  logic reset_n,
  input  logic button,
  input  logic tick,
  output logic ev_press,
  output logic ev_long,
  output logic ev_repeat,
  output logic ev_release
);

  btn_state_t       state;
  logic             prev_button;
  logic [CNT_W-1:0] hold_cnt;
  logic             long_hit;
  logic             repeat_hit;

  assign long_hit   = tick && (hold_cnt == CNT_W'(LONG_MS - 1));
  assign repeat_hit = tick && (hold_cnt == CNT_W'(REPEAT_MS - 1));

  // Strobes are combinational so the pending store captures them on the same edge
  // the FSM advances; release outranks a coincident threshold tick.
  always_comb begin
    ev_press   = (state == IDLE) && button && !prev_button;
    ev_release = (state != IDLE) && !button;
    ev_long    = (state == HELD) && button && long_hit;
    ev_repeat  = (state == REPEAT_HOLD) && button && repeat_hit;
  end

  // State, edge-detect history and hold counter.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      prev_button <= 1'b0;
      hold_cnt    <= '0;
    end else begin
      prev_button <= button;
      case (state)
        IDLE: begin
          if (button && !prev_button) begin
            hold_cnt <= '0;
            state    <= HELD;
          end
        end
        HELD: begin
          if (!button) begin
            hold_cnt <= '0;
            state    <= IDLE;
          end else if (long_hit) begin
            hold_cnt <= '0;
            state    <= REPEAT_HOLD;
          end else if (tick) begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        REPEAT_HOLD: begin
          if (!button) begin
            hold_cnt <= '0;
            state    <= IDLE;
          end else if (repeat_hit) begin
            hold_cnt <= '0;
          end else if (tick) begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: begin
          hold_cnt <= '0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/button_event_ctrl.sv
// rtl/button_event_ctrl.sv - button level activity to arbitrated valid/ready event stream
module button_event_ctrl
  import btn_event_pkg::*;
#(
  parameter int unsigned frequency      = 100000000,
  parameter int unsigned buttons_number = 5,
  parameter int unsigned long_ms        = 1000,
  parameter int unsigned repeat_ms      = 200,
  localparam int unsigned BTN_W = (buttons_number > 1) ? $clog2(buttons_number) : 1
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [buttons_number-1:0] button,
  output logic                      event_valid,
  input  logic                      event_ready,
  output logic [BTN_W-1:0]          event_button,
  output logic [1:0]                event_kind,
  output logic                      overflow,
  input  logic                      overflow_clear
);

  localparam int unsigned TICK_DIV = frequency / MS_DIVISOR;
  localparam int unsigned PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned HOLD_MAX = (long_ms > repeat_ms) ? long_ms : repeat_ms;
  localparam int unsigned CNT_W    = $clog2(HOLD_MAX + 1);

  logic [PRE_W-1:0]                presc;
  logic                            tick;
  logic [buttons_number-1:0][3:0]  set_bits;
  logic [buttons_number-1:0][3:0]  clr_bits;
  logic [buttons_number-1:0][3:0]  pending;
  logic [BTN_W-1:0]                rr_ptr;
  logic [BTN_W-1:0]                win_btn;
  logic [3:0]                      win_pend;
  logic [3:0]                      win_onehot;
  event_kind_t                     win_kind;
  logic                            win_found;
  logic                            grant;
  logic                            drop;

  assign tick = (presc == PRE_W'(TICK_DIV - 1));

  // 1 ms tick prescaler.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) presc <= '0;
    else if (tick) presc <= '0;
    else presc <= presc + 1'b1;
  end

  for (genvar g = 0; g < buttons_number; g++) begin : g_btn
    button_hold_fsm #(
      .LONG_MS  (long_ms),
      .REPEAT_MS(repeat_ms),
      .CNT_W    (CNT_W)
    ) u_fsm (
      .clock     (clock),
      .reset_n   (reset_n),
      .button    (button[g]),
      .tick      (tick),
      .ev_press  (set_bits[g][0]),
      .ev_long   (set_bits[g][1]),
      .ev_repeat (set_bits[g][2]),
      .ev_release(set_bits[g][3])
    );
  end

  // Round-robin button pick: lowest busy index at/after the pointer, else lowest below it;
  // within the button the lowest kind (chronological order) wins.
  always_comb begin
    logic             found_hi, found_lo;
    logic [BTN_W-1:0] hi_btn, lo_btn;
    logic [3:0]       hi_pend, lo_pend;
    found_hi = 1'b0;
    found_lo = 1'b0;
    hi_btn   = '0;
    lo_btn   = '0;
    hi_pend  = '0;
    lo_pend  = '0;
    for (int b = int'(buttons_number) - 1; b >= 0; b--) begin
      if (|pending[b]) begin
        if (BTN_W'(b) >= rr_ptr) begin
          found_hi = 1'b1;
          hi_btn   = BTN_W'(b);
          hi_pend  = pending[b];
        end else begin
          found_lo = 1'b1;
          lo_btn   = BTN_W'(b);
          lo_pend  = pending[b];
        end
      end
    end
    win_found  = found_hi || found_lo;
    win_btn    = found_hi ? hi_btn : lo_btn;
    win_pend   = found_hi ? hi_pend : lo_pend;
    win_onehot = win_pend & (~win_pend + 4'd1);
    if (win_pend[0])      win_kind = EV_PRESS;
    else if (win_pend[1]) win_kind = EV_LONG;
    else if (win_pend[2]) win_kind = EV_REPEAT;
    else                  win_kind = EV_RELEASE;
    grant = (!event_valid || event_ready) && win_found;
    for (int b = 0; b < int'(buttons_number); b++) begin
      clr_bits[b] = (grant && (BTN_W'(b) == win_btn)) ? win_onehot : 4'b0000;
    end
  end

  // A set of an already-pending bit loses the new event; a set racing its own grant survives.
  assign drop = |(set_bits & pending & ~clr_bits);

  // Pending store and sticky overflow; a drop outranks a coincident clear.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pending  <= '0;
      overflow <= 1'b0;
    end else begin
      pending <= (pending & ~clr_bits) | set_bits;
      if (drop) overflow <= 1'b1;
      else if (overflow_clear) overflow <= 1'b0;
    end
  end

  // Event output register and round-robin pointer; outputs hold while stalled.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      event_valid  <= 1'b0;
      event_button <= '0;
      event_kind   <= EV_PRESS;
      rr_ptr       <= '0;
    end else if (grant) begin
      event_valid  <= 1'b1;
      event_button <= win_btn;
      event_kind   <= win_kind;
      rr_ptr       <= (win_btn == BTN_W'(buttons_number - 1)) ? '0 : win_btn + 1'b1;
    end else if (event_ready) begin
      event_valid <= 1'b0;
    end
  end

endmodule
